// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry fetch-to-decode instruction queue; fetch side in_valid/in_ready/in_ins/in_pc, decode side out_valid/out_ready/ir_out/pc_out, count is occupancy, flush empties it
module ir_queue #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int DEPTH  = 4,
  parameter int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_ins,
  input  logic [AWIDTH-1:0] in_pc,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] ir_out,
  output logic [AWIDTH-1:0] pc_out,
  output logic [CWIDTH-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [DWIDTH-1:0] ins_mem [DEPTH];
  logic [AWIDTH-1:0] pc_mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic push, pop;
  assign in_ready  = count != CWIDTH'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ir_out    = out_valid ? ins_mem[rp] : '0;
  assign pc_out    = out_valid ? pc_mem[rp] : '0;
  always_ff @(posedge clk)
    if (!rst && !flush && push) begin
      ins_mem[wp] <= in_ins;
      pc_mem[wp]  <= in_pc;
    end
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= push ? wp + PW'(1) : wp;
      rp    <= pop ? rp + PW'(1) : rp;
      count <= count + CWIDTH'(push) - CWIDTH'(pop);
    end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: randomized scoreboard bench for ir_queue against a queue-based reference model
module tb_ir_queue;
  localparam int DWIDTH = 16;
  localparam int AWIDTH = 16;
  localparam int DEPTH  = 4;
  localparam int CWIDTH = $clog2(DEPTH + 1);
  localparam int NCYC   = 1000;

  typedef struct {
    logic [DWIDTH-1:0] ins;
    logic [AWIDTH-1:0] pc;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DWIDTH-1:0] in_ins, ir_out;
  logic [AWIDTH-1:0] in_pc, pc_out;
  logic [CWIDTH-1:0] count;

  entry_t exp_q[$];
  bit     mon_on = 1'b0;
  int     n_chk = 0;
  int     n_pass = 0;

  ir_queue #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ir_out(ir_out), .pc_out(pc_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Monitor: compares DUT outputs with the model mid-cycle and retires the
  // head entry whenever decode consumes it at the coming edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("ir_out", 32'(ir_out), 32'(exp_q[0].ins));
        chk("pc_out", 32'(pc_out), 32'(exp_q[0].pc));
        if (out_ready && !flush && !rst) void'(exp_q.pop_front());
      end else begin
        chk("ir_out_empty", 32'(ir_out), 32'd0);
        chk("pc_out_empty", 32'(pc_out), 32'd0);
      end
    end
  end

  // Driver: issues random stimulus and pushes accepted entries to the model.
  initial begin
    int pv, pr, pf, prs;
    bit will_push, stalled;
    entry_t item;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = '0; in_pc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_on = 1'b1;
    for (int i = 0; i < NCYC; i++) begin
      case (i / 200)
        0: begin pv = 90;  pr = 15;  pf = 0; prs = 0; end
        1: begin pv = 15;  pr = 90;  pf = 0; prs = 0; end
        2: begin pv = 100; pr = 100; pf = 0; prs = 0; end
        3: begin pv = 70;  pr = 60;  pf = 6; prs = 0; end
        default: begin pv = 50; pr = 50; pf = 4; prs = 3; end
      endcase
      stalled = in_valid && (exp_q.size() == DEPTH) && !rst && !flush;
      rst       = $urandom_range(99) < prs;
      flush     = $urandom_range(99) < pf;
      out_ready = $urandom_range(99) < pr;
      if (stalled) in_valid = 1'b1;
      else begin
        in_valid = $urandom_range(99) < pv;
        in_ins   = DWIDTH'($urandom);
        in_pc    = AWIDTH'($urandom);
      end
      item.ins  = in_ins;
      item.pc   = in_pc;
      will_push = in_valid && !rst && !flush && exp_q.size() != DEPTH;
      @(posedge clk); #1;
      if (rst || flush) exp_q.delete();
      else if (will_push) exp_q.push_back(item);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction prefetch queue between instruction fetch and decode.
- Each entry holds an instruction word tagged with its fetch address.
- Uses valid/ready handshakes on both sides in place of the single enable pair.
- Supports a flush for taken branches and exceptions, and reports occupancy to the fetch unit.

Parameters:
DWIDTH, 16, instruction word width in bits (>=1)
AWIDTH, 16, fetch address (PC tag) width in bits (>=1)
DEPTH, 4, number of queue entries; power of two, >=2
CWIDTH, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all queued entries
in_valid  input  1  fetch presents an instruction this cycle
in_ins  input  DWIDTH  instruction word from fetch
in_pc  input  AWIDTH  address of in_ins
in_ready  output  1  queue can accept an entry this cycle
out_valid  output  1  head entry is available to decode
out_ready  input  1  decode consumes head this cycle
ir_out  output  DWIDTH  head instruction word
pc_out  output  AWIDTH  head instruction address
count  output  CWIDTH  number of valid entries, 0..DEPTH

Behaviour:
- Reset: reset is synchronous and active-high. On a rising edge with rst=1:
  - write pointer, read pointer and count go to 0;
  - out_valid=0, in_ready=1, ir_out=0, pc_out=0.
  - rst has priority over flush, push and pop.
- Storage: circular buffer of DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty is derived from count, not from pointer equality.
- Handshake signals:
  - push = in_valid & in_ready, with in_ready = (count != DEPTH).
  - pop = out_valid & out_ready, with out_valid = (count != 0).
  - in_ready and out_valid depend only on registered state, never combinationally on in_valid or out_ready.
- Latency: an entry pushed at edge N is first visible (out_valid=1, ir_out/pc_out valid) in the cycle after edge N. There is no same-cycle fall-through.
- Head outputs:
  - ir_out/pc_out are driven from the entry at the read pointer when count != 0.
  - They are forced to 0 when count == 0, so an empty queue reads deterministically.
  - They stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, both occur in the same cycle; count is unchanged and both pointers advance.
  - When full, in_ready=0, so only the pop occurs. No push-through when full; in_ready rises the cycle after the pop.
  - When empty, only the push occurs.
- Count update: count_next = count + push - pop; it never exceeds DEPTH and never underflows.
- Flush (rst=0, flush=1):
  - Pointers and count go to 0 at that edge.
  - Any push or pop in the same cycle is discarded: the entry is not stored and the pop has no effect.
  - The cycle after a flush shows out_valid=0, in_ready=1, count=0.
  - Flush on an already empty queue is harmless.
- Holding: with in_valid=0 and out_ready=0, all state is held indefinitely.
- Protocol expectation on fetch: in_ins/in_pc stay stable while in_valid=1 and in_ready=0. The queue does not check this.

Test Plan:
1. Reset, then push 0x1111@0x0000, 0x2222@0x0002, 0x3333@0x0004 on consecutive cycles with out_ready=0 -> count 1,2,3; ir_out=0x1111, pc_out=0x0000 from the cycle after the first push and held; no same-cycle visibility.
2. Fill DEPTH=4 (0xA0..0xA3), keep in_valid=1 with 0xA4 -> in_ready=0, count=4, 0xA4 not stored. Then pop once -> ir_out becomes 0xA1, count=3, in_ready=1 next cycle, 0xA4 accepted on the following edge.
3. Continuous in_valid=1/out_ready=1 over 10 instructions 0x0100..0x0109 -> count steady at 1 after the first cycle; output order 0x0100..0x0109 with matching PCs; pointers wrap past entry 3 with no loss or duplication.
4. Queue holding 3 entries; assert flush together with in_valid=1 (0xBEEF) and out_ready=1 -> next cycle count=0, out_valid=0, ir_out=0, pc_out=0; 0xBEEF absent; the next push is visible alone.
5. Assert rst mid-stream with 2 entries queued and flush=1 -> next cycle count=0, in_ready=1, out_valid=0, outputs 0. Then resume pushing 0x5555 -> it appears as head.
6. Empty queue with out_ready=1 and in_valid=0 for 5 cycles -> count stays 0, out_valid=0, no pointer movement; the next push of 0x7777 appears normally.
